// File: rtl/mem_req_arbiter.sv
// Front end of the PSRAM controller: arbitrates CPU and VIC-II single-byte
// requests, drives one controller transaction at a time and returns an ack.
module mem_req_arbiter #(
  parameter logic [6:0]  BANK          = 7'd0,
  parameter int unsigned VIC_BURST_MAX = 4,
  parameter int unsigned BUSY_WAIT     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        vic_req,
  input  logic [15:0] vic_addr,
  output logic        vic_ack,
  output logic [7:0]  vic_rdata,
  output logic        mc_ce,
  output logic        mc_write,
  output logic [6:0]  mc_bank,
  output logic [15:0] mc_addr,
  output logic [3:0]  mc_nbytes,
  output logic [7:0]  mc_wdata,
  input  logic        mc_busy,
  input  logic [7:0]  mc_rdata,
  output logic        err_timeout
);

  localparam logic [3:0] BURST_MAX = 4'(VIC_BURST_MAX);
  localparam logic [7:0] WAIT_MAX  = 8'(BUSY_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACK
  } state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_VIC
  } owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [15:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  nbytes_q, nbytes_d;
  logic [3:0]  burst_q, burst_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  vic_rdata_q, vic_rdata_d;
  logic        timeout;
  logic        grant_cpu;
  logic        grant_vic;

  // The CPU only beats a waiting VIC once the VIC has had its full burst.
  assign grant_cpu = cpu_req && (!vic_req || (burst_q == BURST_MAX));
  assign grant_vic = vic_req && !grant_cpu;

  always_comb begin
    // NOTE: every next-state signal starts from its held value so no path
    // through the case statement leaves one unassigned (no latches).
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    nbytes_d    = nbytes_q;
    burst_d     = burst_q;
    wait_d      = wait_q;
    cpu_rdata_d = cpu_rdata_q;
    vic_rdata_d = vic_rdata_q;
    timeout     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_cpu) begin
          owner_d  = OWN_CPU;
          addr_d   = cpu_addr;
          write_d  = cpu_write;
          wdata_d  = cpu_wdata;
          nbytes_d = cpu_write ? 4'd1 : 4'd0;
          burst_d  = 4'd0;
          state_d  = S_ISSUE;
        end else if (grant_vic) begin
          owner_d  = OWN_VIC;
          addr_d   = vic_addr;
          write_d  = 1'b0;
          wdata_d  = 8'd0;
          nbytes_d = 4'd0;
          if (!cpu_req)
            burst_d = 4'd0;
          else if (burst_q != BURST_MAX)
            burst_d = burst_q + 4'd1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d  = 8'd0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (mc_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          wait_d = wait_q + 8'd1;
          // Controller never started: flag it and release the master anyway.
          if (wait_d == WAIT_MAX) begin
            timeout = 1'b1;
            state_d = S_ACK;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!mc_busy) begin
          if (!write_q) begin
            if (owner_q == OWN_CPU) cpu_rdata_d = mc_rdata;
            else                    vic_rdata_d = mc_rdata;
          end
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_CPU;
      addr_q      <= 16'd0;
      write_q     <= 1'b0;
      wdata_q     <= 8'd0;
      nbytes_q    <= 4'd0;
      burst_q     <= 4'd0;
      wait_q      <= 8'd0;
      cpu_rdata_q <= 8'd0;
      vic_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      nbytes_q    <= nbytes_d;
      burst_q     <= burst_d;
      wait_q      <= wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      vic_rdata_q <= vic_rdata_d;
    end
  end

  assign mc_ce       = (state_q == S_ISSUE);
  assign mc_write    = write_q;
  assign mc_bank     = BANK;
  assign mc_addr     = addr_q;
  assign mc_nbytes   = nbytes_q;
  assign mc_wdata    = wdata_q;
  assign cpu_ack     = (state_q == S_ACK) && (owner_q == OWN_CPU);
  assign vic_ack     = (state_q == S_ACK) && (owner_q == OWN_VIC);
  assign cpu_rdata   = cpu_rdata_q;
  assign vic_rdata   = vic_rdata_q;
  assign err_timeout = timeout;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: a behavioural PSRAM controller, a cycle monitor
// and a directed/randomised sequence checked against a transaction-level model.
module tb_mem_req_arbiter;

  localparam logic [6:0] BANK          = 7'h2A;
  localparam int         VIC_BURST_MAX = 4;
  localparam int         BUSY_WAIT     = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_write, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        vic_req, vic_ack;
  logic [15:0] vic_addr;
  logic [7:0]  vic_rdata;
  logic        mc_ce, mc_write, mc_busy, err_timeout;
  logic [6:0]  mc_bank;
  logic [15:0] mc_addr;
  logic [3:0]  mc_nbytes;
  logic [7:0]  mc_wdata, mc_rdata;

  mem_req_arbiter #(
    .BANK(BANK), .VIC_BURST_MAX(VIC_BURST_MAX), .BUSY_WAIT(BUSY_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vic_req(vic_req), .vic_addr(vic_addr), .vic_ack(vic_ack), .vic_rdata(vic_rdata),
    .mc_ce(mc_ce), .mc_write(mc_write), .mc_bank(mc_bank), .mc_addr(mc_addr),
    .mc_nbytes(mc_nbytes), .mc_wdata(mc_wdata), .mc_busy(mc_busy),
    .mc_rdata(mc_rdata), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Power-on contents of the external memory, shared by controller and model.
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // ---------------- behavioural PSRAM controller ----------------
  logic [7:0]  ctl_mem [logic [15:0]];
  int          ctl_lat   = 1;
  bit          ctl_stuck = 0;
  logic [15:0] ctl_a;
  logic        ctl_w;

  initial begin
    mc_busy  = 1'b0;
    mc_rdata = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (mc_ce && !ctl_stuck) begin
        ctl_a = mc_addr;
        ctl_w = mc_write;
        if (ctl_w) ctl_mem[ctl_a] = mc_wdata;
        @(posedge clk); #2;
        mc_busy  = 1'b1;
        mc_rdata = 8'($urandom);
        repeat (ctl_lat) @(posedge clk);
        #2;
        mc_busy = 1'b0;
        if (!ctl_w) mc_rdata = ctl_mem.exists(ctl_a) ? ctl_mem[ctl_a] : init_byte(ctl_a);
      end
    end
  end

  // ---------------- cycle monitor ----------------
  int          cyc = 0;
  int          ce_cnt = 0, ce_cyc = 0;
  int          cack_cnt = 0, cack_cyc = 0;
  int          vack_cnt = 0, vack_cyc = 0;
  int          err_cnt = 0, err_cyc = 0;
  int          stab_bad = 0;
  logic [7:0]  cack_data, vack_data;
  logic [15:0] ce_addr;
  logic        ce_write;
  logic [3:0]  ce_nbytes;
  logic [7:0]  ce_wdata;
  bit          active = 0;
  bit          grant_q[$];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      active = 0;
    end else begin
      if (active && (mc_addr !== ce_addr || mc_write !== ce_write ||
                     mc_nbytes !== ce_nbytes || mc_wdata !== ce_wdata))
        stab_bad++;
      if (mc_ce) begin
        ce_cnt++;
        ce_cyc    = cyc;
        ce_addr   = mc_addr;
        ce_write  = mc_write;
        ce_nbytes = mc_nbytes;
        ce_wdata  = mc_wdata;
        active    = 1;
      end
      if (cpu_ack) begin
        cack_cnt++;
        cack_cyc  = cyc;
        cack_data = cpu_rdata;
        grant_q.push_back(1'b0);
        active    = 0;
      end
      if (vic_ack) begin
        vack_cnt++;
        vack_cyc  = cyc;
        vack_data = vic_rdata;
        grant_q.push_back(1'b1);
        active    = 0;
      end
      if (err_timeout) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [logic [15:0]];
  logic [7:0] exp_cpu_rdata = 8'h00;
  logic [7:0] exp_vic_rdata = 8'h00;

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // One complete transaction from a single master, released on time after ack.
  task automatic txn(input bit is_vic, input bit wr, input logic [15:0] a,
                     input logic [7:0] d, input int b);
    int ce0, ack0, t, ack_cyc, data;
    ctl_lat = b;
    ce0  = ce_cnt;
    ack0 = is_vic ? vack_cnt : cack_cnt;
    if (is_vic) begin
      vic_req = 1'b1; vic_addr = a;
    end else begin
      cpu_req = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
    end
    t = 0;
    while (((is_vic ? vack_cnt : cack_cnt) == ack0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    cpu_req = 1'b0;
    vic_req = 1'b0;
    repeat (4) @(negedge clk);
    check("ack_seen", ((is_vic ? vack_cnt : cack_cnt) - ack0), 1);
    check("ce_single", ce_cnt - ce0, 1);
    check("ce_addr", ce_addr, a);
    check("ce_write", ce_write, is_vic ? 1'b0 : wr);
    check("ce_nbytes", ce_nbytes, (!is_vic && wr) ? 4'd1 : 4'd0);
    if (wr) begin
      check("ce_wdata", ce_wdata, d);
      ref_mem[a] = d;
    end
    ack_cyc = is_vic ? vack_cyc : cack_cyc;
    check("ack_latency", ack_cyc - ce_cyc, b + 2);
    if (is_vic) begin
      exp_vic_rdata = ref_read(a);
      data = vack_data;
      check("vic_rdata", data, exp_vic_rdata);
    end else begin
      if (!wr) exp_cpu_rdata = ref_read(a);
      data = cack_data;
      check("cpu_rdata", data, exp_cpu_rdata);
    end
  endtask

  int          ce0, a0, e0, t;
  bit          rv, rw;
  logic [15:0] ra;
  int          streak;
  bit          exp_vic;

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    vic_req = 1'b0; vic_addr = 16'h0;
    ctl_mem[16'h0801] = 8'h0B;
    ref_mem[16'h0801] = 8'h0B;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outs",
          {mc_ce, mc_write, mc_addr, mc_nbytes, mc_wdata, cpu_ack, vic_ack,
           err_timeout, cpu_rdata, vic_rdata}, 64'd0);
    check("reset_bank", mc_bank, BANK);
    reset = 1'b0;
    @(negedge clk);

    // Directed CPU write then read
    txn(1'b0, 1'b1, 16'hD020, 8'h0E, 3);
    txn(1'b0, 1'b0, 16'h0801, 8'h00, 2);
    txn(1'b1, 1'b0, 16'h0400, 8'h00, 2);

    // Reset while the controller is busy
    ctl_lat = 6;
    ce0 = ce_cnt; a0 = cack_cnt;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0801;
    t = 0;
    while (ce_cnt == ce0 && t < 50) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("midrst_outs",
          {mc_ce, mc_write, mc_addr, mc_nbytes, mc_wdata, cpu_ack, vic_ack,
           err_timeout, cpu_rdata, vic_rdata}, 64'd0);
    check("midrst_bank", mc_bank, BANK);
    reset = 1'b0;
    exp_cpu_rdata = 8'h00;
    exp_vic_rdata = 8'h00;
    repeat (12) @(negedge clk);
    check("midrst_no_ack", cack_cnt - a0, 0);
    check("midrst_no_reissue", ce_cnt - ce0, 1);
    txn(1'b0, 1'b0, 16'h0801, 8'h00, 2);

    // Busy timeout: master released with rdata untouched
    ctl_stuck = 1'b1;
    ce0 = ce_cnt; a0 = cack_cnt; e0 = err_cnt;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h2000;
    t = 0;
    while (cack_cnt == a0 && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    ctl_stuck = 1'b0;
    check("to_ack", cack_cnt - a0, 1);
    check("to_err_pulse", err_cnt - e0, 1);
    check("to_err_cycle", err_cyc - ce_cyc, BUSY_WAIT);
    check("to_ack_cycle", cack_cyc - err_cyc, 1);
    check("to_rdata_kept", cack_data, exp_cpu_rdata);

    // Request held one cycle past ack: exactly one extra transaction
    ctl_lat = 2;
    ce0 = ce_cnt; a0 = cack_cnt;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0801;
    t = 0;
    while (cack_cnt == a0 && t < 100) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    cpu_req = 1'b0;
    repeat (20) @(negedge clk);
    check("late_drop_ce", ce_cnt - ce0, 2);
    check("late_drop_ack", cack_cnt - a0, 2);

    // Randomised single-master traffic over a small address pool
    for (int i = 0; i < 16; i++) begin
      rv = 1'($urandom_range(0, 1));
      rw = rv ? 1'b0 : 1'($urandom_range(0, 1));
      ra = 16'h1000 + 16'($urandom_range(0, 3));
      txn(rv, rw, ra, 8'($urandom), $urandom_range(1, 5));
    end

    // Both masters requesting continuously: VIC bursts, CPU gets every fifth
    grant_q.delete();
    ctl_lat = 1;
    cpu_write = 1'b0; cpu_addr = 16'h3000; vic_addr = 16'h3100;
    cpu_req = 1'b1; vic_req = 1'b1;
    t = 0;
    while (grant_q.size() < 15 && t < 1000) begin @(negedge clk); t++; end
    cpu_req = 1'b0; vic_req = 1'b0;
    repeat (20) @(negedge clk);
    check("burst_count", grant_q.size(), 15);
    streak = 0;
    for (int i = 0; i < 15 && i < grant_q.size(); i++) begin
      if (streak == VIC_BURST_MAX) begin
        exp_vic = 1'b0;
        streak  = 0;
      end else begin
        exp_vic = 1'b1;
        streak++;
      end
      check($sformatf("grant%0d_is_vic", i), grant_q[i], exp_vic);
    end
    check("burst_cpu_rdata", cack_data, ref_read(16'h3000));
    check("burst_vic_rdata", vack_data, ref_read(16'h3100));
    check("addr_stable", stab_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
